tristate_bus_driver: RTL and testbench
======================================

Name: tristate_bus_driver

Overview:
- Parametrised, clocked successor to the single-pin tristate output: drives a WIDTH-bit bidirectional pin group on iCE40 through one SB_IO per bit.
- Adds push-pull or open-drain mode, a handshaked drive/release command interface, and an enforced high-Z turnaround dead time on every direction change.
- Adds synchronised pin readback.
- Sits between protocol engines (parallel bus, shared I2C/1-wire style lines) and package pins.

Parameters:
- WIDTH, 8, number of pins in the group (1..32).
- OPEN_DRAIN, 0, 0 = push-pull; 1 = each bit driven low only, never high.
- TURNAROUND, 2, high-Z dead-time cycles inserted on each direction change (0..255).
- PULLUP, 0, value passed to the SB_IO PULLUP for every bit.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; synchronous, active-high.
- pin  inout  WIDTH  package pins.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  command accepted on cycles where cmd_valid && cmd_ready.
- cmd_drive  input  1  1 = drive the bus, 0 = release it to high-Z.
- cmd_value  input  WIDTH  value to drive; ignored when cmd_drive = 0.
- driving  output  1  1 while the pins are actively driven (state DRIVE).
- sample  output  WIDTH  pin levels after 2-FF synchroniser.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values, while rst is high and on the first edge after it drops:
  - all output enables 0 (pins high-Z); out register 0;
  - state HIZ; cmd_ready 0 during rst, 1 from the first cycle after rst deasserts;
  - driving 0; sample 0; turnaround counter 0.
- States:
  - HIZ: pins released.
  - DRIVE: pins driven from the out register.
  - TURN: dead time, all pins high-Z; target direction held in a dir_next flag.
- cmd_ready = 1 in HIZ and DRIVE, 0 in TURN.
- Accepted command, same direction:
  - HIZ + drive=0: no-op.
  - DRIVE + drive=1: out register takes cmd_value at that edge; the pin reflects it one cycle later because of the registered SB_IO output. Back-to-back accepts give one new value per cycle.
- Accepted command, direction change with TURNAROUND > 0:
  - At that edge: output enables go 0, counter loads TURNAROUND-1, dir_next is latched, state goes to TURN.
  - For drive=1, cmd_value is latched into the out register at the same edge.
  - TURN decrements the counter each cycle. When the counter reads 0, the next state is dir_next.
  - Result: exactly TURNAROUND cycles with cmd_ready = 0 and pins high-Z, then DRIVE with output enables asserted, or HIZ.
- Accepted command, direction change with TURNAROUND = 0:
  - Goes straight to the new state; TURN is never entered; cmd_ready stays 1.
- Output enable per bit:
  - push-pull: oe = (state == DRIVE).
  - open-drain: oe = (state == DRIVE) & ~out[i], SB_IO data input tied 0.
  - An open-drain '1' is never driven; it is released to the pull-up.
- SB_IO configuration: PIN_TYPE 6'b1101_01, i.e. registered output and output enable, unregistered input.
- Input path: SB_IO D_IN_0 feeds a 2-FF synchroniser, so sample lags the pin by 2 clk. Sample is valid in every state, so an open-drain bus is read back while driving.
- Reset mid-operation: rst in TURN or DRIVE releases the pins at the same edge (oe is registered, so pins go high-Z one cycle later at most) and aborts the turnaround. A pending dir_next is discarded.
- cmd_valid while cmd_ready = 0: the command is not accepted; the master must hold it stable. No buffering.
- The counter is $clog2(TURNAROUND+1) bits wide (minimum 1) and never wraps: it only decrements in TURN and stops at 0.

Decomposition:
- Shared include (tristate_defs.vh): state encodings HIZ=2'd0, DRIVE=2'd1, TURN=2'd2; SB_IO PIN_TYPE constants for registered and combinational tristate.
- Sub-module tristate_io_cell: one SB_IO plus the per-bit oe/open-drain gating, instantiated WIDTH times in a generate loop.
- The top level holds the FSM, counter, out register and synchroniser.

Test Plan:
- Reset, then a drive cmd_value=8'hA5, TURNAROUND=2 -> cmd_ready low for exactly 2 cycles, pins Z for those cycles, then pin=8'hA5 one cycle after oe asserts; driving=1; sample=8'hA5 2 cycles later.
- In DRIVE, 4 back-to-back accepts 8'h01,8'h02,8'h04,8'h08 -> pins follow one per cycle with 1-cycle latency; cmd_ready stays 1.
- DRIVE, then a release command -> oe=0 at the next edge, 2 TURN cycles, state HIZ; an external bench driver putting 8'h3C on the bus after the dead time -> sample=8'h3C with no contention.
- OPEN_DRAIN=1, PULLUP=1, drive 8'hF0 -> low nibble driven 0, high nibble high-Z (reads 1); bench pulls bit 7 low -> sample=8'h70.
- TURNAROUND=0, alternate drive/release every cycle -> cmd_ready constantly 1 and direction changes each cycle.
- rst asserted in cycle 1 of TURN toward DRIVE -> pins stay Z, state HIZ, driving=0, cmd_ready=1 the cycle after rst drops.

Source files
------------

// File: rtl/tristate_bus_driver_pkg.sv
// ============================================================================
// Module      : tristate_bus_driver_pkg
// Description : Shared state encoding, pad configuration constants and
//               helper function for the tristate bus driver.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tristate_bus_driver_pkg;

    typedef enum logic [1:0] {
        ST_HIZ   = 2'd0,
        ST_DRIVE = 2'd1,
        ST_TURN  = 2'd2
    } state_t;

    // iCE40 SB_IO PIN_TYPE codes: registered vs combinational tristate output.
    localparam logic [5:0] c_pin_type_reg_tri  = 6'b1101_01;
    localparam logic [5:0] c_pin_type_comb_tri = 6'b1010_01;

    function automatic int cnt_width(input int ta);
        return (ta > 0) ? $clog2(ta + 1) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tristate_bus_driver_io.sv
// ============================================================================
// Module      : tristate_io_cell
// Description : One bidirectional pad: registered output/enable with an
//               unregistered input, equivalent to SB_IO PIN_TYPE 6'b1101_01.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tristate_io_cell #(
    parameter int OPEN_DRAIN = 0,
    parameter int PULLUP     = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic drive_en,
    input  logic dout,
    inout  wire  pad,
    output logic din
);

    logic w_oe;
    logic w_dout;
    logic r_oe;
    logic r_dout;

    // Open-drain only ever pulls low; a '1' is released to the pull-up.
    assign w_oe   = drive_en & ((OPEN_DRAIN != 0) ? ~dout : 1'b1);
    assign w_dout = (OPEN_DRAIN != 0) ? 1'b0 : dout;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_oe   <= 1'b0;
            r_dout <= 1'b0;
        end else begin
            r_oe   <= w_oe;
            r_dout <= w_dout;
        end
    end

    assign pad = r_oe ? r_dout : 1'bz;
    assign din = pad;

    if (PULLUP != 0) begin : g_pullup
        pullup u_pullup (pad);
    end

endmodule

`default_nettype wire

// File: rtl/tristate_bus_driver.sv
// ============================================================================
// Module      : tristate_bus_driver
// Description : WIDTH-bit bidirectional pin group with drive/release command
//               handshake, high-Z turnaround dead time and synchronised readback.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tristate_bus_driver
    import tristate_bus_driver_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int OPEN_DRAIN = 0,
    parameter int TURNAROUND = 2,
    parameter int PULLUP     = 0
) (
    input  logic             clk,
    input  logic             rst,
    inout  wire  [WIDTH-1:0] pin,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_drive,
    input  logic [WIDTH-1:0] cmd_value,
    output logic             driving,
    output logic [WIDTH-1:0] sample
);

    localparam int                 c_cnt_w    = cnt_width(TURNAROUND);
    localparam logic [c_cnt_w-1:0] c_cnt_load = (TURNAROUND > 0) ?
                                                c_cnt_w'(TURNAROUND - 1) : '0;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic               r_dir_next;
    logic               w_dir_nxt;
    logic [WIDTH-1:0]   r_out;
    logic [WIDTH-1:0]   w_out_nxt;
    logic [WIDTH-1:0]   r_sync1;
    logic [WIDTH-1:0]   r_sync2;
    logic [WIDTH-1:0]   w_din;
    logic               w_accept;
    logic               w_drive_en;

    assign cmd_ready  = ~rst && (r_state != ST_TURN);
    assign w_accept   = cmd_valid && cmd_ready;
    assign w_drive_en = (r_state == ST_DRIVE);
    assign driving    = w_drive_en;
    assign sample     = r_sync2;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_dir_nxt   = r_dir_next;
        w_out_nxt   = r_out;
        case (r_state)
            ST_HIZ: begin
                if (w_accept && cmd_drive) begin
                    w_out_nxt = cmd_value;
                    if (TURNAROUND == 0) begin
                        w_state_nxt = ST_DRIVE;
                    end else begin
                        w_state_nxt = ST_TURN;
                        w_cnt_nxt   = c_cnt_load;
                        w_dir_nxt   = 1'b1;
                    end
                end
            end
            ST_DRIVE: begin
                if (w_accept) begin
                    if (cmd_drive) begin
                        w_out_nxt = cmd_value;
                    end else if (TURNAROUND == 0) begin
                        w_state_nxt = ST_HIZ;
                    end else begin
                        w_state_nxt = ST_TURN;
                        w_cnt_nxt   = c_cnt_load;
                        w_dir_nxt   = 1'b0;
                    end
                end
            end
            ST_TURN: begin
                // Counter parks at zero; the exit takes the latched direction.
                if (r_cnt == '0) begin
                    w_state_nxt = r_dir_next ? ST_DRIVE : ST_HIZ;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_HIZ;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_HIZ;
            r_cnt      <= '0;
            r_dir_next <= 1'b0;
            r_out      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_dir_next <= w_dir_nxt;
            r_out      <= w_out_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_din;
            r_sync2 <= r_sync1;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        tristate_io_cell #(
            .OPEN_DRAIN (OPEN_DRAIN),
            .PULLUP     (PULLUP)
        ) u_cell (
            .clk      (clk),
            .rst      (rst),
            .drive_en (w_drive_en),
            .dout     (r_out[i]),
            .pad      (pin[i]),
            .din      (w_din[i])
        );
    end

endmodule

`default_nettype wire

// File: tb/tb_tristate_bus_driver.sv
// ============================================================================
// Module      : tb_tristate_bus_driver
// Description : Push-pull (TURNAROUND=2) and open-drain (TURNAROUND=0, pull-up)
//               instances checked every cycle against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tristate_bus_driver;

    localparam int W     = 8;
    localparam int PP_TA = 2;
    localparam int OD_TA = 0;

    typedef struct packed {
        int         busy;
        logic       drv;
        logic       tgt;
        logic [7:0] outv;
    } mdl_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         pp_valid = 1'b0, pp_drive = 1'b0;
    logic [W-1:0] pp_value = '0;
    logic         pp_ready, pp_driving;
    logic [W-1:0] pp_sample;
    wire  [W-1:0] pp_pin;
    logic [W-1:0] pp_ext_en = '0, pp_ext_val = '0;

    logic         od_valid = 1'b0, od_drive = 1'b0;
    logic [W-1:0] od_value = '0;
    logic         od_ready, od_driving;
    logic [W-1:0] od_sample;
    wire  [W-1:0] od_pin;
    logic [W-1:0] od_ext_en = '0, od_ext_val = '0;

    for (genvar i = 0; i < W; i++) begin : g_ext
        assign pp_pin[i] = pp_ext_en[i] ? pp_ext_val[i] : 1'bz;
        assign od_pin[i] = od_ext_en[i] ? od_ext_val[i] : 1'bz;
    end

    tristate_bus_driver #(.WIDTH(W), .OPEN_DRAIN(0), .TURNAROUND(PP_TA), .PULLUP(0)) u_pp (
        .clk(clk), .rst(rst), .pin(pp_pin), .cmd_valid(pp_valid), .cmd_ready(pp_ready),
        .cmd_drive(pp_drive), .cmd_value(pp_value), .driving(pp_driving), .sample(pp_sample));

    tristate_bus_driver #(.WIDTH(W), .OPEN_DRAIN(1), .TURNAROUND(OD_TA), .PULLUP(1)) u_od (
        .clk(clk), .rst(rst), .pin(od_pin), .cmd_valid(od_valid), .cmd_ready(od_ready),
        .cmd_drive(od_drive), .cmd_value(od_value), .driving(od_driving), .sample(od_sample));

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp,
                         input logic [31:0] mask);
        if (mask == 32'd0) return;
        n_checks++;
        if (((act ^ exp) & mask) == 32'd0) n_pass++;
        else $display("FAIL %s: got %h expected %h (mask %h) at %0t", nm, act, exp, mask, $time);
    endtask

    // Abstract model: "busy" counts remaining dead cycles, drv is whether the bus is owned.
    function automatic mdl_t step(input mdl_t m, input logic r, input logic v, input logic d,
                                  input logic [7:0] val, input int ta);
        mdl_t n = m;
        if (r) return '0;
        if (m.busy > 0) begin
            n.busy = m.busy - 1;
            if (n.busy == 0) n.drv = m.tgt;
        end else if (v) begin
            if (d) n.outv = val;
            if (d != m.drv) begin
                if (ta == 0) n.drv = d;
                else begin
                    n.drv  = 1'b0;
                    n.busy = ta;
                    n.tgt  = d;
                end
            end
        end
        return n;
    endfunction

    function automatic logic [7:0] bus_val(input logic [7:0] pm, input logic [7:0] pv,
                                           input logic [7:0] em, input logic [7:0] ev, input bit pu);
        logic [7:0] r;
        for (int i = 0; i < 8; i++)
            r[i] = pm[i] ? pv[i] : (em[i] ? ev[i] : pu);
        return r;
    endfunction

    function automatic logic [7:0] bus_known(input logic [7:0] pm, input logic [7:0] em, input bit pu);
        return pm | em | (pu ? 8'hFF : 8'h00);
    endfunction

    mdl_t       pp_m = '0, od_m = '0;
    logic [7:0] pp_pm = '0, pp_pv = '0, pp_s1 = '0, pp_s1k = '0, pp_s2 = '0, pp_s2k = '0;
    logic [7:0] od_pm = '0, od_pv = '0, od_s1 = '0, od_s1k = '0, od_s2 = '0, od_s2k = '0;
    logic [7:0] b, k;
    bit         chk_en = 1'b0;

    always @(posedge clk) begin
        b = bus_val(pp_pm, pp_pv, pp_ext_en, pp_ext_val, 1'b0);
        k = bus_known(pp_pm, pp_ext_en, 1'b0);
        if (rst) begin
            pp_s1 = '0; pp_s1k = 8'hFF; pp_s2 = '0; pp_s2k = 8'hFF; pp_pm = '0; pp_pv = '0;
        end else begin
            pp_s2 = pp_s1; pp_s2k = pp_s1k; pp_s1 = b; pp_s1k = k;
            pp_pm = pp_m.drv ? 8'hFF : 8'h00;
            pp_pv = pp_m.outv;
        end
        pp_m = step(pp_m, rst, pp_valid, pp_drive, pp_value, PP_TA);

        b = bus_val(od_pm, od_pv, od_ext_en, od_ext_val, 1'b1);
        k = bus_known(od_pm, od_ext_en, 1'b1);
        if (rst) begin
            od_s1 = '0; od_s1k = 8'hFF; od_s2 = '0; od_s2k = 8'hFF; od_pm = '0; od_pv = '0;
        end else begin
            od_s2 = od_s1; od_s2k = od_s1k; od_s1 = b; od_s1k = k;
            od_pm = od_m.drv ? ~od_m.outv : 8'h00;
            od_pv = 8'h00;
        end
        od_m = step(od_m, rst, od_valid, od_drive, od_value, OD_TA);
        chk_en = 1'b1;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("pp_ready",   32'(pp_ready),   32'(!rst && pp_m.busy == 0), 32'd1);
            check("pp_driving", 32'(pp_driving), 32'(pp_m.drv), 32'd1);
            check("pp_pin",     32'(pp_pin), 32'(bus_val(pp_pm, pp_pv, pp_ext_en, pp_ext_val, 1'b0)),
                  32'(bus_known(pp_pm, pp_ext_en, 1'b0)));
            check("pp_sample",  32'(pp_sample), 32'(pp_s2), 32'(pp_s2k));
            check("od_ready",   32'(od_ready),   32'(!rst && od_m.busy == 0), 32'd1);
            check("od_driving", 32'(od_driving), 32'(od_m.drv), 32'd1);
            check("od_pin",     32'(od_pin), 32'(bus_val(od_pm, od_pv, od_ext_en, od_ext_val, 1'b1)),
                  32'(bus_known(od_pm, od_ext_en, 1'b1)));
            check("od_sample",  32'(od_sample), 32'(od_s2), 32'(od_s2k));
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [7:0] seq [4] = '{8'h01, 8'h02, 8'h04, 8'h08};
    bit pp_will, od_will;

    initial begin
        rst = 1'b1;
        tick(3);
        @(negedge clk);
        check("lit_rst_ready",   32'(pp_ready),   32'd0, 32'd1);
        check("lit_rst_driving", 32'(pp_driving), 32'd0, 32'd1);
        check("lit_rst_sample",  32'(pp_sample),  32'd0, 32'hFF);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("lit_ready_after_rst", 32'(pp_ready), 32'd1, 32'd1);

        // Drive A5 through a two-cycle dead time.
        pp_valid = 1'b1; pp_drive = 1'b1; pp_value = 8'hA5;
        tick();
        pp_valid = 1'b0;
        @(negedge clk); check("lit_turn1_ready", 32'(pp_ready), 32'd0, 32'd1);
        check("lit_turn1_driving", 32'(pp_driving), 32'd0, 32'd1);
        tick();
        @(negedge clk); check("lit_turn2_ready", 32'(pp_ready), 32'd0, 32'd1);
        tick();
        @(negedge clk); check("lit_drive_ready", 32'(pp_ready), 32'd1, 32'd1);
        check("lit_drive_driving", 32'(pp_driving), 32'd1, 32'd1);
        tick();
        @(negedge clk); check("lit_pin_a5", 32'(pp_pin), 32'hA5, 32'hFF);
        tick(2);
        @(negedge clk); check("lit_sample_a5", 32'(pp_sample), 32'hA5, 32'hFF);

        // Back-to-back updates while driving.
        for (int i = 0; i < 4; i++) begin
            pp_valid = 1'b1; pp_drive = 1'b1; pp_value = seq[i];
            tick();
            @(negedge clk);
            check("lit_b2b_ready", 32'(pp_ready), 32'd1, 32'd1);
            if (i > 0) check("lit_b2b_pin", 32'(pp_pin), 32'(seq[i-1]), 32'hFF);
        end
        pp_valid = 1'b0;
        tick();
        @(negedge clk); check("lit_b2b_last", 32'(pp_pin), 32'h08, 32'hFF);

        // Release, then an external driver owns the bus.
        pp_valid = 1'b1; pp_drive = 1'b0;
        tick();
        pp_valid = 1'b0;
        @(negedge clk); check("lit_rel_ready", 32'(pp_ready), 32'd0, 32'd1);
        check("lit_rel_driving", 32'(pp_driving), 32'd0, 32'd1);
        tick();
        @(negedge clk); check("lit_rel_ready2", 32'(pp_ready), 32'd0, 32'd1);
        tick();
        @(negedge clk); check("lit_hiz_ready", 32'(pp_ready), 32'd1, 32'd1);
        pp_ext_en = 8'hFF; pp_ext_val = 8'h3C;
        tick(2);
        @(negedge clk); check("lit_ext_sample", 32'(pp_sample), 32'h3C, 32'hFF);
        pp_ext_en = 8'h00;

        // Reset in the first dead-time cycle toward DRIVE.
        pp_valid = 1'b1; pp_drive = 1'b1; pp_value = 8'h55;
        tick();
        pp_valid = 1'b0; rst = 1'b1;
        @(negedge clk); check("lit_rstturn_ready", 32'(pp_ready), 32'd0, 32'd1);
        tick();
        rst = 1'b0;
        @(negedge clk); check("lit_abort_ready", 32'(pp_ready), 32'd1, 32'd1);
        check("lit_abort_driving", 32'(pp_driving), 32'd0, 32'd1);
        tick(3);
        @(negedge clk); check("lit_abort_driving2", 32'(pp_driving), 32'd0, 32'd1);

        // Open-drain with pull-up: F0 drives only the low nibble.
        od_valid = 1'b1; od_drive = 1'b1; od_value = 8'hF0;
        tick();
        od_valid = 1'b0;
        @(negedge clk); check("lit_od_ready", 32'(od_ready), 32'd1, 32'd1);
        check("lit_od_driving", 32'(od_driving), 32'd1, 32'd1);
        tick();
        @(negedge clk); check("lit_od_pin", 32'(od_pin), 32'hF0, 32'hFF);
        od_ext_en = 8'h80; od_ext_val = 8'h00;
        tick(2);
        @(negedge clk); check("lit_od_sample_70", 32'(od_sample), 32'h70, 32'hFF);
        od_ext_en = 8'h00;

        // Zero dead time: direction flips every cycle.
        for (int i = 0; i < 6; i++) begin
            od_valid = 1'b1; od_drive = i[0];
            tick();
            @(negedge clk);
            check("lit_ta0_ready",   32'(od_ready),   32'd1, 32'd1);
            check("lit_ta0_driving", 32'(od_driving), 32'(i[0]), 32'd1);
        end
        od_valid = 1'b0;
        tick();

        // Randomised traffic; a refused command is held until accepted.
        for (int c = 0; c < 400; c++) begin
            pp_will = pp_valid && !rst && pp_m.busy == 0;
            od_will = od_valid && !rst && od_m.busy == 0;
            tick();
            rst = ($urandom_range(0, 49) == 0);
            if (!pp_valid || pp_will) begin
                pp_valid = ($urandom_range(0, 3) != 0);
                pp_drive = 1'($urandom_range(0, 1));
                pp_value = 8'($urandom);
            end
            if (!od_valid || od_will) begin
                od_valid = ($urandom_range(0, 3) != 0);
                od_drive = 1'($urandom_range(0, 1));
                od_value = 8'($urandom);
            end
            od_ext_en  = ($urandom_range(0, 3) == 0) ? 8'($urandom & $urandom) : 8'h00;
            od_ext_val = 8'h00;
        end
        rst = 1'b0; pp_valid = 1'b0; od_valid = 1'b0; od_ext_en = 8'h00;
        tick(4);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
